// File: rtl/powlib_pkg.sv
// Shared types and sizing helpers for the powlib stream blocks.
package powlib_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbiter_state_t;

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One spare bit so BURST-1 always fits, including BURST values that are powers of two.
  function automatic int count_width(input int burst);
    return $clog2(burst) + 1;
  endfunction

endpackage

// File: rtl/stream_arbiter_pick.sv
// Combinational rotate-priority encoder: first set bit of valid scanning upward from start, wrapping N-1 -> 0.
module stream_arbiter_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] winner
);

  int pos;

  // Walk the scan order backwards so the earliest candidate is the last one written.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      if (valid[pos[IW-1:0]]) begin
        found  = 1'b1;
        winner = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin arbiter sharing one registered stream output among N requesters, bursts of up to BURST words.
// Define STREAM_ARBITER_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins (no pointer register).
module stream_arbiter
  import powlib_pkg::*;
#(
  parameter type T      = logic [31:0],
  parameter int  N      = 4,
  parameter int  BURST  = 4,
  localparam int IW     = index_width(N),
  localparam int CW     = count_width(BURST)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  receiver_valid,
  output logic [N-1:0]  receiver_ready,
  input  T              receiver_data [N],
  output logic          sender_valid,
  input  logic          sender_ready,
  output T              sender_data,
  output logic          grant_valid,
  output logic [IW-1:0] grant_index
);

  localparam logic [CW-1:0] LAST_COUNT = CW'(BURST - 1);

  arbiter_state_t state, state_next;
  logic [IW-1:0]  grant_next;
  logic [CW-1:0]  count, count_next;
  logic           load;
  logic           transfer;
  logic           release_grant;
  logic           pick_found;
  logic [IW-1:0]  pick_winner;
  logic [IW-1:0]  pick_start;

`ifdef STREAM_ARBITER_FIXED_PRIORITY_EN
  assign pick_start = '0;
`else
  localparam logic [IW-1:0] LAST_INDEX = IW'(N - 1);
  logic [IW-1:0] pointer, pointer_next;
  assign pick_start = pointer;
`endif

  stream_arbiter_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .valid  (receiver_valid),
    .start  (pick_start),
    .found  (pick_found),
    .winner (pick_winner)
  );

  assign load          = !sender_valid || sender_ready;
  assign transfer      = (state == GRANT) && receiver_valid[grant_index] && load;
  assign release_grant = (state == GRANT) &&
                         (!receiver_valid[grant_index] || (transfer && count == LAST_COUNT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant_index <= '0;
      count       <= '0;
`ifndef STREAM_ARBITER_FIXED_PRIORITY_EN
      pointer     <= '0;
`endif
    end else begin
      state       <= state_next;
      grant_index <= grant_next;
      count       <= count_next;
`ifndef STREAM_ARBITER_FIXED_PRIORITY_EN
      pointer     <= pointer_next;
`endif
    end
  end

  // A requester dropping valid gives up the grant at once so an idle producer cannot stall the others.
  always_comb begin
    state_next   = state;
    grant_next   = grant_index;
    count_next   = count;
`ifndef STREAM_ARBITER_FIXED_PRIORITY_EN
    pointer_next = pointer;
`endif
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          grant_next = pick_winner;
          count_next = '0;
        end
      end
      GRANT: begin
        if (release_grant) begin
          state_next   = IDLE;
          count_next   = '0;
`ifndef STREAM_ARBITER_FIXED_PRIORITY_EN
          pointer_next = (grant_index == LAST_INDEX) ? '0 : grant_index + 1'b1;
`endif
        end else if (transfer) begin
          count_next = count + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_valid    = (state == GRANT);
    receiver_ready = '0;
    if ((state == GRANT) && load) receiver_ready[grant_index] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sender_valid <= 1'b0;
    end else if (transfer) begin
      sender_valid <= 1'b1;
    end else if (sender_ready) begin
      sender_valid <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while sender_valid is high.
  always_ff @(posedge clock) begin
    if (transfer) sender_data <= receiver_data[grant_index];
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: transaction-level model checked every cycle plus literal scenario expectations.
// Follows STREAM_ARBITER_FIXED_PRIORITY_EN the same way the design does.
`timescale 1ns/1ps
module tb_stream_arbiter;

  localparam int N     = 4;
  localparam int BURST = 4;

`ifdef STREAM_ARBITER_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] receiver_valid;
  logic [N-1:0] receiver_ready;
  logic [31:0]  receiver_data [N];
  logic         sender_valid;
  logic         sender_ready;
  logic [31:0]  sender_data;
  logic         grant_valid;
  logic [1:0]   grant_index;

  int checks = 0;
  int errors = 0;

  bit          en    [N];
  logic [31:0] base  [N];
  int          limit [N];
  int          mark  [N];
  int          sent  [N] = '{default: 0};

  stream_arbiter #(
    .T     (logic [31:0]),
    .N     (N),
    .BURST (BURST)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .receiver_valid (receiver_valid),
    .receiver_ready (receiver_ready),
    .receiver_data  (receiver_data),
    .sender_valid   (sender_valid),
    .sender_ready   (sender_ready),
    .sender_data    (sender_data),
    .grant_valid    (grant_valid),
    .grant_index    (grant_index)
  );

  always #5 clock = ~clock;

  // Each producer offers base+k for its k-th word since it was configured, up to limit words.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      receiver_valid[i] = en[i] && ((sent[i] - mark[i]) < limit[i]);
      receiver_data[i]  = base[i] + 32'(sent[i] - mark[i]);
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < N; i++)
      if (receiver_valid[i] && receiver_ready[i]) sent[i] <= sent[i] + 1;
  end

  // Reference model: who holds the grant, words delivered in this burst, and the single output slot.
  int          mGrant = -1;
  int          mIndex = 0;
  int          mPtr   = 0;
  int          mWords = 0;
  int          mStart;
  bit          mTake;
  bit          mOutValid = 1'b0;
  logic [31:0] mOutData  = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mGrant    = -1;
      mIndex    = 0;
      mPtr      = 0;
      mWords    = 0;
      mOutValid = 1'b0;
    end else if (mGrant < 0) begin
      if (sender_ready) mOutValid = 1'b0;
      mStart = FIXED ? 0 : mPtr;
      for (int k = 0; k < N; k++)
        if (mGrant < 0 && receiver_valid[(mStart + k) % N]) mGrant = (mStart + k) % N;
      if (mGrant >= 0) begin
        mIndex = mGrant;
        mWords = 0;
      end
    end else begin
      mTake = receiver_valid[mGrant] && (!mOutValid || sender_ready);
      if (mTake) begin
        mOutData  = receiver_data[mGrant];
        mOutValid = 1'b1;
        mWords    = mWords + 1;
      end else if (sender_ready) begin
        mOutValid = 1'b0;
      end
      if (!receiver_valid[mGrant] || mWords == BURST) begin
        mPtr   = (mGrant + 1) % N;
        mGrant = -1;
        mWords = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  bit           checkOn = 1'b0;
  bit           prevGv  = 1'b0;
  logic [31:0]  outLog [$];
  int           grantLog [$];
  logic [N-1:0] expReady;

  always @(negedge clock) begin
    if (checkOn) begin
      expReady = '0;
      if (mGrant >= 0 && (!mOutValid || sender_ready)) expReady[mGrant] = 1'b1;
      checkOutput("sender_valid", 32'(sender_valid), 32'(mOutValid));
      if (mOutValid) checkOutput("sender_data", sender_data, mOutData);
      checkOutput("grant_valid", 32'(grant_valid), 32'(mGrant >= 0));
      checkOutput("grant_index", 32'(grant_index), 32'(mIndex));
      checkOutput("receiver_ready", 32'(receiver_ready), 32'(expReady));
      if (sender_valid && sender_ready) outLog.push_back(sender_data);
      if (grant_valid && !prevGv) grantLog.push_back(int'(grant_index));
      prevGv = grant_valid;
    end
  end

  function automatic logic [31:0] outAt(input int idx);
    return (idx < outLog.size()) ? outLog[idx] : 32'hDEAD_BEEF;
  endfunction

  function automatic int grantAt(input int idx);
    return (idx < grantLog.size()) ? grantLog[idx] : -1;
  endfunction

  task automatic applyStimulus(input int idx, input bit enable, input logic [31:0] baseVal, input int lim);
    en[idx]    = enable;
    base[idx]  = baseVal;
    limit[idx] = lim;
    mark[idx]  = sent[idx];
  endtask

  task automatic clearAll();
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b0, 32'd0, 0);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic resetDut();
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      checkOutput("reset_sender_valid", 32'(sender_valid), 32'd0);
      checkOutput("reset_receiver_ready", 32'(receiver_ready), 32'd0);
      checkOutput("reset_grant_valid", 32'(grant_valid), 32'd0);
    end
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  int          oStart;
  int          gStart;
  bit          seen;
  logic [31:0] exp3 [6];
  logic [31:0] expWord;

  initial begin
    reset        = 1'b0;
    sender_ready = 1'b1;
    for (int i = 0; i < N; i++) applyStimulus(i, 1'b1, 32'(i) << 12, 1000);
    checkOn = 1'b1;

    // Reset with every requester pending, then requester 0 wins one cycle after release.
    resetDut();
    @(posedge clock);
    #1;
    checkOutput("t1_grant_valid", 32'(grant_valid), 32'd1);
    checkOutput("t1_grant_index", 32'(grant_index), 32'd0);
    checkOutput("t1_ready", 32'(receiver_ready), 32'b0001);
    clearAll();
    waitCycles(6);

`ifndef STREAM_ARBITER_FIXED_PRIORITY_EN
    // Requesters 0 and 2 alternate bursts of four.
    clearAll();
    applyStimulus(0, 1'b1, 32'h100, 1000);
    applyStimulus(2, 1'b1, 32'h200, 1000);
    oStart = outLog.size();
    gStart = grantLog.size();
    resetDut();
    waitCycles(24);
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < 4; j++) begin
        expWord = ((b % 2 == 0) ? 32'h100 : 32'h200) + 32'((b / 2) * 4 + j);
        checkOutput("t2_word", outAt(oStart + b * 4 + j), expWord);
      end
    for (int g = 0; g < 4; g++)
      checkOutput("t2_grant", 32'(grantAt(gStart + g)), (g % 2 == 0) ? 32'd0 : 32'd2);
    clearAll();
    waitCycles(6);
`endif

    // Requester 1 leaves after two words; requester 3 is next at or above index 2.
    clearAll();
    applyStimulus(1, 1'b1, 32'hA0, 2);
    applyStimulus(3, 1'b1, 32'h300, 4);
    oStart = outLog.size();
    gStart = grantLog.size();
    resetDut();
    waitCycles(14);
    exp3 = '{32'hA0, 32'hA1, 32'h300, 32'h301, 32'h302, 32'h303};
    for (int j = 0; j < 6; j++) checkOutput("t3_word", outAt(oStart + j), exp3[j]);
    checkOutput("t3_word_count", 32'(outLog.size() - oStart), 32'd6);
    checkOutput("t3_grant_first", 32'(grantAt(gStart)), 32'd1);
    checkOutput("t3_grant_second", 32'(grantAt(gStart + 1)), 32'd3);
    checkOutput("t3_grant_count", 32'(grantLog.size() - gStart), 32'd2);

    // Backpressure after the first word of requester 3 holds the word and the grant.
    clearAll();
    applyStimulus(3, 1'b1, 32'h300, 4);
    sender_ready = 1'b1;
    oStart = outLog.size();
    gStart = grantLog.size();
    resetDut();
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clock);
      #1;
      seen = sender_valid;
    end
    checkOutput("t4_first_word_seen", 32'(seen), 32'd1);
    sender_ready = 1'b0;
    repeat (5) begin
      @(posedge clock);
      #1;
      checkOutput("t4_hold_data", sender_data, 32'h300);
      checkOutput("t4_hold_ready", 32'(receiver_ready), 32'd0);
      checkOutput("t4_hold_grant", 32'(grant_index), 32'd3);
    end
    sender_ready = 1'b1;
    waitCycles(8);
    for (int j = 0; j < 4; j++) checkOutput("t4_word", outAt(oStart + j), 32'h300 + 32'(j));
    checkOutput("t4_word_count", 32'(outLog.size() - oStart), 32'd4);
    checkOutput("t4_grant_count", 32'(grantLog.size() - gStart), 32'd1);
    checkOutput("t4_released", 32'(grant_valid), 32'd0);

`ifndef STREAM_ARBITER_FIXED_PRIORITY_EN
    // Reset mid-burst of requester 1; afterwards the scan starts again at index 0.
    clearAll();
    applyStimulus(0, 1'b1, 32'h500, 4);
    applyStimulus(1, 1'b1, 32'h600, 1000);
    resetDut();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clock);
      #1;
      seen = sender_valid && (sender_data == 32'h601);
    end
    checkOutput("t5_word2_seen", 32'(seen), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_async_sender_valid", 32'(sender_valid), 32'd0);
    checkOutput("t5_async_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("t5_async_ready", 32'(receiver_ready), 32'd0);
    oStart = outLog.size();
    gStart = grantLog.size();
    applyStimulus(0, 1'b1, 32'h700, 4);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    waitCycles(4);
    checkOutput("t5_grant_after_reset", 32'(grantAt(gStart)), 32'd0);
    checkOutput("t5_word_after_reset", outAt(oStart), 32'h700);
`else
    // Fixed priority: requester 1 always beats requester 3.
    clearAll();
    applyStimulus(1, 1'b1, 32'h1000, 1000);
    applyStimulus(3, 1'b1, 32'h3000, 1000);
    oStart = outLog.size();
    gStart = grantLog.size();
    resetDut();
    waitCycles(20);
    checkOutput("t6_grant_count", 32'(grantLog.size() - gStart), 32'd4);
    for (int g = 0; g < 4; g++) checkOutput("t6_grant", 32'(grantAt(gStart + g)), 32'd1);
    for (int j = 0; j < 12; j++) checkOutput("t6_word", outAt(oStart + j), 32'h1000 + 32'(j));
`endif

    clearAll();
    waitCycles(4);
    checkOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- N-input round-robin arbiter sharing one stream sink (typically an sfifo receiver) among N stream requesters.
- Grants one requester at a time for a burst of up to BURST transfers.
- Registers the winning word into an output stage with valid/ready semantics identical to sfifo's sender side.
- Sits between multiple producers and a shared buffer or downstream channel.

Parameters:
- T, logic[31:0], payload type.
- N, 4, number of requesters (>=2).
- BURST, 4, max consecutive transfers per grant (>=1).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- receiver_valid  input  N  per-requester valid.
- receiver_ready  output  N  per-requester ready; at most one bit set.
- receiver_data  input  N x $bits(T)  per-requester payload, unpacked array of T.
- sender_valid  output  1  output stage holds a word.
- sender_ready  input  1  downstream accepts.
- sender_data  output  $bits(T)  output word.
- grant_valid  output  1  high in GRANT state.
- grant_index  output  $clog2(N)  current/last granted requester.

Behaviour:
- Reset (reset==0, async): sender_valid=0, state=IDLE, grant_valid=0, grant_index=0, priority pointer=0, burst count=0. sender_data is not reset. A reset mid-burst discards any held output word.
- load = !sender_valid || sender_ready.
- receiver_ready[i] = (state==GRANT) && (grant_index==i) && load. All other bits are 0.
- transfer = receiver_valid[g] && receiver_ready[g], where g = grant_index.
- State IDLE:
  - If any receiver_valid is set, pick the first valid requester scanning from pointer upward with wrap N-1 -> 0.
  - Next cycle: state=GRANT, grant_index=winner, count=0.
  - Arbitration costs one bubble cycle. No ready is asserted in IDLE.
- State GRANT, release when either:
  - (a) transfer && count==BURST-1, or
  - (b) !receiver_valid[g] (requester went idle; release the same cycle).
- On release: state=IDLE, pointer = (g==N-1) ? 0 : g+1, count=0.
- Otherwise, on transfer, count increments. count width is $clog2(BURST)+1 and never exceeds BURST-1.
- Output stage:
  - On transfer: sender_data <= receiver_data[g], sender_valid <= 1.
  - Else if sender_ready: sender_valid <= 0.
  - Latency is 1 cycle from input handshake to sender_valid.
  - Full throughput (1 word/cycle) within a burst when sender_ready is held high.
- Backpressure: with sender_valid=1 and sender_ready=0, load=0, so no requester is ready. The grant is held and count is frozen (the requester must keep valid or it loses the grant per (b)).
- Data from one requester is never reordered. Words from different bursts appear in grant order.
- Single requester: re-granted after each release, costing 1 idle cycle per BURST words.

Optional Feature:
- Macro STREAM_ARBITER_FIXED_PRIORITY_EN.
- Defined: the IDLE pick always scans from index 0 (lowest index wins). The pointer register is removed, and BURST and the release rules are unchanged.
- Undefined: round-robin as above.

Decomposition:
- Shared package powlib_pkg holds:
  - arbiter_state_t enum {IDLE, GRANT};
  - a helper function/localparam rule for index width ($clog2(N)) and count width.
- One sub-module, stream_arbiter_pick: purely combinational rotate-priority encoder.
  - Inputs: valid vector, start pointer.
  - Outputs: found, winner index.
  - Reused under the macro with start tied to 0.

Test Plan (N=4, BURST=4, T=logic[31:0]):
- Reset held 0 for 3 cycles with all receiver_valid=1 -> sender_valid=0, receiver_ready=0000, grant_valid=0. Release reset: grant to index 0 one cycle later.
- Requesters 0 and 2 both valid continuously, data 0x100+k and 0x200+k, sender_ready=1 -> output 0x100..0x103, one bubble, 0x200..0x203, bubble, 0x104..; grant_index alternates 0, 2.
- Requester 1 valid for only 2 words (0xA0, 0xA1), then drops -> released after 2 transfers; pointer moves to 2; the next grant goes to the next valid requester at or above index 2.
- Grant 3, sender_ready=0 for 5 cycles after the first word 0x300 -> sender_data stays 0x300, receiver_ready=0000, count frozen at 1. On ready, 0x301..0x303 flow; release after 4 total words.
- Async reset pulsed low mid-burst (after word 2 of 4) -> sender_valid drops immediately without a clock edge; after release, arbitration restarts from pointer 0.
- With STREAM_ARBITER_FIXED_PRIORITY_EN, requesters 1 and 3 always valid -> only index 1 is granted, bursts of 4 separated by 1 bubble; requester 3 is never granted.
